// File: rtl/instr_fetch.sv
// Fetch stage between the pc register and the decoder: one outstanding imem request, holds the reply until the decoder accepts it.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] NOP_INSTR      = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] pc,
   input  logic              flush,
   input  logic              dec_ready,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   output logic              stall,
   output logic              fetch_err
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                imem_req_q, imem_req_d;
   logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
   logic [31:0]         instr_q, instr_d;
   logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
   logic                instr_valid_q, instr_valid_d;
   logic                squash_q, squash_d;
   logic                fetch_err_q, fetch_err_d;
   logic                timeout_c;

`ifdef FETCH_TIMEOUT_EN
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   // Watchdog: cleared while requesting, counts WAIT cycles without a reply
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == S_REQ) begin
         cnt_d = '0;
      end else if (state_q == S_WAIT && !imem_ack) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign timeout_c = (state_q == S_WAIT) && !imem_ack &&
                      (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{CNT_W, TIMEOUT_CYCLES};
   assign timeout_c  = 1'b0;
`endif

   // Next-state and registered-output computation
   always_comb begin
      state_d       = state_q;
      imem_req_d    = imem_req_q;
      imem_addr_d   = imem_addr_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      squash_d      = squash_q;
      fetch_err_d   = fetch_err_q;
      case (state_q)
         S_REQ: begin
            if (!flush) begin
               imem_addr_d = pc;
               imem_req_d  = 1'b1;
               state_d     = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_ack || timeout_c) begin
               imem_req_d = 1'b0;
               squash_d   = 1'b0;
               // a flush in the same cycle as the reply squashes it too
               if (squash_q || flush) begin
                  state_d = S_REQ;
               end else begin
                  instr_d       = imem_ack ? imem_rdata : NOP_INSTR;
                  instr_pc_d    = imem_addr_q;
                  instr_valid_d = 1'b1;
                  fetch_err_d   = fetch_err_q | ~imem_ack;
                  state_d       = S_HOLD;
               end
            end else if (flush) begin
               squash_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (flush || dec_ready) begin
               instr_valid_d = 1'b0;
               state_d       = S_REQ;
            end
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_REQ;
         imem_req_q    <= 1'b0;
         imem_addr_q   <= '0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         squash_q      <= 1'b0;
         fetch_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         imem_req_q    <= imem_req_d;
         imem_addr_q   <= imem_addr_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         squash_q      <= squash_d;
         fetch_err_q   <= fetch_err_d;
      end
   end

   // pc may only advance when the held instruction is consumed without a redirect
   assign stall       = ~((state_q == S_HOLD) && dec_ready && !flush);
   assign imem_req    = imem_req_q;
   assign imem_addr   = imem_addr_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
`ifdef FETCH_TIMEOUT_EN
   assign fetch_err   = fetch_err_q;
`else
   assign fetch_err   = 1'b0;
   logic unused_err;
   assign unused_err  = fetch_err_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: handshake, stall, flush/squash, reset mid-fetch, optional timeout.
module tb_instr_fetch;

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned TB_TIMEOUT = 4;
`else
   localparam int unsigned TB_TIMEOUT = 255;
`endif

   logic        clk;
   logic        rst_n;
   logic [31:0] pc;
   logic        flush;
   logic        dec_ready;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        stall;
   logic        fetch_err;

   int checks   = 0;
   int failures = 0;

   instr_fetch #(
      .ADDR_W         (32),
      .TIMEOUT_CYCLES (TB_TIMEOUT),
      .NOP_INSTR      (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc          (pc),
      .flush       (flush),
      .dec_ready   (dec_ready),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .stall       (stall),
      .fetch_err   (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n      = 1'b0;
      pc         = 32'h10;
      flush      = 1'b0;
      dec_ready  = 1'b1;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      #12;
      chk("rst_req",    32'(imem_req),    32'd0);
      chk("rst_addr",   imem_addr,        32'h0);
      chk("rst_instr",  instr,            32'h0);
      chk("rst_ipc",    instr_pc,         32'h0);
      chk("rst_valid",  32'(instr_valid), 32'd0);
      chk("rst_err",    32'(fetch_err),   32'd0);
      chk("rst_stall",  32'(stall),       32'd1);
      step();
      rst_n = 1'b1;

      // 1: basic fetch, ack in first WAIT cycle
      step();
      chk("t1_req",   32'(imem_req), 32'd1);
      chk("t1_addr",  imem_addr,     32'h10);
      chk("t1_stall", 32'(stall),    32'd1);
      imem_ack = 1'b1; imem_rdata = 32'h8C22_0004;
      step();
      imem_ack = 1'b0;
      chk("t1_valid", 32'(instr_valid), 32'd1);
      chk("t1_instr", instr,            32'h8C22_0004);
      chk("t1_ipc",   instr_pc,         32'h10);
      chk("t1_req0",  32'(imem_req),    32'd0);
      chk("t1_stall0", 32'(stall),      32'd0);
      step();
      pc = 32'h11;
      chk("t1_stall1", 32'(stall),      32'd1);
      chk("t1_vdrop",  32'(instr_valid), 32'd0);

      // 2: decoder back-pressure in HOLD
      dec_ready = 1'b0;
      step();
      chk("t2_addr", imem_addr, 32'h11);
      imem_ack = 1'b1; imem_rdata = 32'h0022_1820;
      step();
      imem_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold_valid", 32'(instr_valid), 32'd1);
         chk("t2_hold_instr", instr,            32'h0022_1820);
         chk("t2_hold_ipc",   instr_pc,         32'h11);
         chk("t2_hold_stall", 32'(stall),       32'd1);
         step();
      end
      dec_ready = 1'b1;
      #1;
      chk("t2_stall0", 32'(stall), 32'd0);
      step();
      pc = 32'h12;
      chk("t2_stall1", 32'(stall), 32'd1);
      step();
      chk("t2_next_addr", imem_addr,     32'h12);
      chk("t2_next_req",  32'(imem_req), 32'd1);

      // 3: flush while waiting, late reply discarded
      flush = 1'b1;
      step();
      flush = 1'b0;
      pc = 32'h40;
      chk("t3_req_held",  32'(imem_req), 32'd1);
      chk("t3_addr_held", imem_addr,     32'h12);
      step();
      step();
      chk("t3_wait_valid", 32'(instr_valid), 32'd0);
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      step();
      imem_ack = 1'b0;
      chk("t3_sq_valid", 32'(instr_valid), 32'd0);
      chk("t3_sq_req",   32'(imem_req),    32'd0);
      chk("t3_sq_instr", instr,            32'h0022_1820);
      step();
      chk("t3_new_addr", imem_addr,     32'h40);
      chk("t3_new_req",  32'(imem_req), 32'd1);

      // 4: flush and dec_ready together in HOLD
      imem_ack = 1'b1; imem_rdata = 32'h2001_0005;
      step();
      imem_ack = 1'b0;
      chk("t4_instr", instr, 32'h2001_0005);
      chk("t4_ipc",   instr_pc, 32'h40);
      flush = 1'b1;
      #1;
      chk("t4_stall", 32'(stall), 32'd1);
      step();
      flush = 1'b0;
      pc = 32'h80;
      chk("t4_vdrop",  32'(instr_valid), 32'd0);
      chk("t4_stall1", 32'(stall),       32'd1);
      step();
      chk("t4_new_addr", imem_addr, 32'h80);

      // 5: async reset mid-WAIT, stray ack after release
      step();
      rst_n = 1'b0;
      #1;
      chk("t5_req",   32'(imem_req),    32'd0);
      chk("t5_addr",  imem_addr,        32'h0);
      chk("t5_stall", 32'(stall),       32'd1);
      pc = 32'h90;
      step();
      rst_n = 1'b1;
      imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
      step();
      imem_ack = 1'b0;
      chk("t5_valid", 32'(instr_valid), 32'd0);
      chk("t5_addr2", imem_addr,        32'h90);
      chk("t5_req2",  32'(imem_req),    32'd1);
      imem_ack = 1'b1; imem_rdata = 32'h3C01_1234;
      step();
      imem_ack = 1'b0;
      chk("t5_instr", instr,    32'h3C01_1234);
      chk("t5_ipc",   instr_pc, 32'h90);

      // 6: no reply at all
      step();
      pc = 32'h91;
      step();
      chk("t6_addr", imem_addr, 32'h91);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t6_wait_req", 32'(imem_req), 32'd1);
      end
      step();
`ifdef FETCH_TIMEOUT_EN
      chk("t6_valid", 32'(instr_valid), 32'd1);
      chk("t6_instr", instr,            32'h0);
      chk("t6_ipc",   instr_pc,         32'h91);
      chk("t6_err",   32'(fetch_err),   32'd1);
      step();
      pc = 32'h92;
      step();
      imem_ack = 1'b1; imem_rdata = 32'h0000_0020;
      step();
      imem_ack = 1'b0;
      chk("t6_instr2", instr,          32'h0000_0020);
      chk("t6_sticky", 32'(fetch_err), 32'd1);
`else
      for (int i = 0; i < 10; i++) step();
      chk("t6_still_wait", 32'(imem_req),    32'd1);
      chk("t6_no_valid",   32'(instr_valid), 32'd0);
      chk("t6_no_err",     32'(fetch_err),   32'd0);
      imem_ack = 1'b1; imem_rdata = 32'h0000_0020;
      step();
      imem_ack = 1'b0;
      chk("t6_instr2", instr, 32'h0000_0020);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
